// File: rtl/instr_fetch_pkg.sv
// Shared CPU front-end definitions: widths, NOP encoding, fetch FSM states
// and the fetch entry payload used by fetch and decode.
package instr_fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP = INSTR_W'(0);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // One fetched instruction together with the word address it came from.
  typedef struct packed {
    pc_t    addr;
    instr_t data;
  } fetch_entry_t;

  function automatic pc_t pc_inc(input pc_t pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory port: read request out, read data back one cycle later.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic   imem_re;
  pc_t    imem_addr;
  instr_t imem_rdata;

  modport master (output imem_re, output imem_addr, input imem_rdata);
  modport slave  (input imem_re, input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a response that arrived while decode stalled.
module fetch_skid_buf
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  // Clear wins over load so a discarded response never survives a redirect.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, stall/flush/halt control and the
// registered fetch-to-decode outputs.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  pc_t           redirect_pc,
  input  logic          hlt,
  instr_fetch_if.master imem,
  output instr_t        instr,
  output pc_t           PC_out,
  output pc_t           PC_plus1,
  output logic          instr_valid
);

  fetch_state_t state, state_nxt;
  pc_t          pc, pc_nxt;
  logic         inflight, inflight_nxt;
  pc_t          inflight_addr, inflight_addr_nxt;

  logic         skid_load, skid_unload, skid_clear, skid_valid;
  fetch_entry_t skid_entry, resp, take_entry;
  logic         out_nop, out_take;

  assign resp.addr = inflight_addr;
  assign resp.data = imem.imem_rdata;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .load_entry (resp),
    .entry      (skid_entry),
    .valid      (skid_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state, memory request and output-register selection.
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    inflight_nxt      = 1'b0;
    inflight_addr_nxt = inflight_addr;
    imem.imem_re      = 1'b0;
    imem.imem_addr    = pc;
    skid_load         = 1'b0;
    skid_unload       = 1'b0;
    skid_clear        = 1'b0;
    out_nop           = 1'b0;
    out_take          = 1'b0;
    take_entry        = '0;

    if (flush) begin
      state_nxt  = FETCH;
      pc_nxt     = redirect_pc;
      skid_clear = 1'b1;
      out_nop    = 1'b1;
    end else begin
      case (state)
        HALT: begin
          out_nop = 1'b1;
        end
        default: begin
          if (hlt) begin
            state_nxt  = HALT;
            skid_clear = 1'b1;
            out_nop    = 1'b1;
          end else if (stall) begin
            state_nxt = STALL;
            skid_load = inflight;
          end else begin
            state_nxt         = FETCH;
            imem.imem_re      = !rst;
            pc_nxt            = pc_inc(pc);
            inflight_nxt      = 1'b1;
            inflight_addr_nxt = pc;
            // A skidded response is always older than anything in flight.
            if (skid_valid) begin
              out_take    = 1'b1;
              take_entry  = skid_entry;
              skid_unload = 1'b1;
            end else if (inflight) begin
              out_take   = 1'b1;
              take_entry = resp;
            end else begin
              out_nop = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      instr         <= NOP;
      PC_out        <= '0;
      PC_plus1      <= PC_W'(1);
      instr_valid   <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      inflight      <= inflight_nxt;
      inflight_addr <= inflight_addr_nxt;
      if (out_nop) begin
        instr       <= NOP;
        instr_valid <= 1'b0;
      end else if (out_take) begin
        instr       <= take_entry.data;
        PC_out      <= take_entry.addr;
        PC_plus1    <= pc_inc(take_entry.addr);
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table, hand-written
// corner sequences and a random-stall ordering scoreboard.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  typedef struct {
    logic rst, stall, flush, hlt;
    pc_t  rpc;
    logic ere;
    pc_t  eaddr;
    logic evalid;
    pc_t  epc;
    logic chkpc;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst, stall, flush, hlt;
  pc_t    redirect_pc;
  instr_t instr;
  pc_t    PC_out, PC_plus1;
  logic   instr_valid;

  int checks = 0;
  int errors = 0;

  instr_fetch_if imem ();

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .hlt         (hlt),
    .imem        (imem.master),
    .instr       (instr),
    .PC_out      (PC_out),
    .PC_plus1    (PC_plus1),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic instr_t mem_word(input pc_t a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Memory answers one cycle after a read; garbage otherwise.
  always @(posedge clk)
    imem.imem_rdata <= imem.imem_re ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;

  function automatic vec_t mk(input logic r, s, f, h, input pc_t rp,
                              input logic ere, input pc_t ea,
                              input logic ev, input pc_t ep, input logic cp);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.hlt = h; v.rpc = rp;
    v.ere = ere; v.eaddr = ea; v.evalid = ev; v.epc = ep; v.chkpc = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check the request before the edge and the outputs after it.
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; stall = v.stall; flush = v.flush; hlt = v.hlt; redirect_pc = v.rpc;
    #1;
    chk({tag, " imem_re"}, 32'(imem.imem_re), 32'(v.ere));
    if (v.ere) chk({tag, " imem_addr"}, 32'(imem.imem_addr), 32'(v.eaddr));
    @(posedge clk); #1;
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(v.evalid));
    chk({tag, " instr"}, instr, v.evalid ? mem_word(v.epc) : NOP);
    if (v.chkpc) begin
      chk({tag, " PC_out"}, 32'(PC_out), 32'(v.epc));
      chk({tag, " PC_plus1"}, 32'(PC_plus1), 32'(pc_t'(v.epc + 16'd1)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    pc_t  exp_q[$];
    pc_t  e, last_pc;
    logic last_valid, s;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; hlt = 1'b0; redirect_pc = '0;

    // Reset, start-up stream, 3-cycle stall at PC_out=5, halt at 9, flush to 0x20.
    tbl.push_back(mk(1,0,0,0,0, 0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 0,0,0));
    for (int k = 3; k <= 8; k++)
      tbl.push_back(mk(0,0,0,0,0, 1,pc_t'(k-2), 1,pc_t'(k-3),1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,1,0,0,0, 0,0, 1,16'd5,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0,0, 1,pc_t'(7+k), 1,pc_t'(6+k),1));
    tbl.push_back(mk(0,0,0,1,0, 0,0, 0,0,0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0,logic'(k%2),0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,0,16'h0020, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,16'h0020, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,16'h0021, 1,16'h0020,1));
    tbl.push_back(mk(0,0,0,0,0, 1,16'h0022, 1,16'h0021,1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Flush while stalled with a full skid: skid content must be dropped.
    apply(mk(0,1,0,0,0,       0,0,       1,16'h0021,1), "fls stall");
    apply(mk(0,1,1,0,16'h0040, 0,0,       0,0,0),       "fls flush");
    apply(mk(0,0,0,0,0,       1,16'h0040, 0,0,0),       "fls first");
    apply(mk(0,0,0,0,0,       1,16'h0041, 1,16'h0040,1), "fls pc40");
    apply(mk(0,0,0,0,0,       1,16'h0042, 1,16'h0041,1), "fls pc41");

    // PC wrap through 0xFFFF.
    apply(mk(0,0,1,0,16'hFFFE, 0,0,       0,0,0),       "wrap flush");
    apply(mk(0,0,0,0,0,       1,16'hFFFE, 0,0,0),       "wrap first");
    apply(mk(0,0,0,0,0,       1,16'hFFFF, 1,16'hFFFE,1), "wrap fffe");
    apply(mk(0,0,0,0,0,       1,16'h0000, 1,16'hFFFF,1), "wrap ffff");
    apply(mk(0,0,0,0,0,       1,16'h0001, 1,16'h0000,1), "wrap 0000");

    // Reset during a stall with the skid occupied.
    apply(mk(0,1,0,0,0, 0,0, 1,16'h0000,1), "rst stall1");
    apply(mk(0,1,0,0,0, 0,0, 1,16'h0000,1), "rst stall2");
    apply(mk(1,1,0,0,0, 0,0, 0,16'h0000,1), "rst assert");
    apply(mk(0,0,0,0,0, 1,16'h0000, 0,0,0),  "rst first");
    apply(mk(0,0,0,0,0, 1,16'h0001, 1,16'h0000,1), "rst pc0");
    apply(mk(0,0,0,0,0, 1,16'h0002, 1,16'h0001,1), "rst pc1");

    // Random stalls: every instruction must come out once, in order.
    for (int i = 0; i < 24; i++) exp_q.push_back(pc_t'(16'h1000 + i));
    apply(mk(0,0,1,0,16'h1000, 0,0, 0,0,0), "sb flush");
    last_valid = 1'b0;
    last_pc    = '0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      s = ($urandom_range(0, 9) < 4);
      rst = 1'b0; flush = 1'b0; hlt = 1'b0; stall = s;
      #1;
      chk("sb imem_re", 32'(imem.imem_re), 32'(!s));
      @(posedge clk); #1;
      if (s) begin
        chk("sb hold valid", 32'(instr_valid), 32'(last_valid));
        if (last_valid) chk("sb hold pc", 32'(PC_out), 32'(last_pc));
      end else if (instr_valid) begin
        e = exp_q.pop_front();
        chk("sb pc", 32'(PC_out), 32'(e));
        chk("sb instr", instr, mem_word(e));
        last_valid = 1'b1;
        last_pc    = e;
      end
    end
    chk("sb drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  decode-stage hazard; hold the current fetch-to-decode outputs.
REQ-005 flush  input  1  redirect request from branch resolution or misprediction.
REQ-006 redirect_pc  input  16  target word address, sampled when flush=1.
REQ-007 hlt  input  1  halt decoded downstream; stop fetching.
REQ-008 imem_re  output  1  instruction memory read enable.
REQ-009 imem_addr  output  16  instruction memory word address.
REQ-010 imem_rdata  input  32  read data, valid exactly 1 cycle after imem_re=1.
REQ-011 instr  output  32  registered instruction to decode.
REQ-012 PC_out  output  16  registered address of instr.
REQ-013 PC_plus1  output  16  PC_out+1, mod 2^16, for branch predictor/link.
REQ-014 instr_valid  output  1  instr is a real fetched instruction; NOP bubble otherwise.

Function
REQ-015 Internal state: pc (16b), one-entry skid buffer (data, address, valid), inflight flag, FSM {FETCH, STALL, HALT}.
REQ-016 FETCH with stall=0: imem_re=1, imem_addr=pc, pc<=pc+1; each response loads instr/PC_out next edge with instr_valid=1; steady-state throughput 1 instr/cycle.
REQ-017 pc increment SHALL wrap 16'hFFFF -> 16'h0000; PC_plus1 wraps identically.
REQ-018 FETCH->STALL when stall=1: imem_re=0, pc held, instr/PC_out/instr_valid held unchanged.
REQ-019 A response arriving during STALL SHALL be captured in the skid buffer; no fetch is ever lost or duplicated.
REQ-020 STALL->FETCH when stall=0: a valid skid entry is delivered to the outputs first (skid cleared) while fetch of pc resumes the same cycle.
REQ-021 flush=1 SHALL override stall and hlt in any state: pc<=redirect_pc, skid and inflight response discarded, next edge instr=32'h0, instr_valid=0, state<=FETCH.
REQ-022 The first fetch after flush SHALL be issued the cycle after flush, at redirect_pc; its instruction appears at the outputs 2 cycles after flush.
REQ-023 hlt=1 (flush=0) from FETCH or STALL: state<=HALT, imem_re=0; the inflight response and skid are discarded; outputs go to instr=32'h0, instr_valid=0 at the next edge.
REQ-024 HALT SHALL persist until rst or flush; stall is ignored in HALT.
REQ-025 imem_re SHALL be 0 whenever rst=1, state is HALT, or stall=1.

Reset
REQ-026 While rst=1 at an edge: pc=16'h0000, state=FETCH, skid valid=0, inflight=0, instr=32'h0, PC_out=16'h0000, PC_plus1=16'h0001, instr_valid=0.
REQ-027 The first fetch (address 0) SHALL occur in the first cycle with rst=0; instr_valid first rises 2 edges after reset deassertion.
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard all pending state with no output glitch beyond the reset values.

Structure
REQ-029 PC width (16), instruction width (32), the NOP encoding (32'h0) and the FSM state enum SHALL reside in the shared CPU package, also used by instr_decode.
REQ-030 The skid buffer SHALL be a separate sub-module, fetch_skid_buf (one entry, load/unload/clear).

Verification
REQ-031 Reset then run with memory word n = 32'hA000_0000+n: instr_valid rises 2 cycles after reset; instr sequence A0000000, A0000001, ... with PC_out 0, 1, 2.
REQ-032 stall=1 for 3 cycles while PC_out=5: outputs frozen at 5, no imem_re; after release, PC_out 6, 7 with no gap or duplicate.
REQ-033 flush=1 with redirect_pc=16'h0040 while stall=1: next cycle instr=0, valid=0; fetch of addr 0x40; PC_out=0x40 two cycles after flush.
REQ-034 hlt=1 at PC_out=9: imem_re drops next cycle, instr_valid=0, outputs remain NOP for 10 cycles; a later flush to 0x20 resumes fetching at 0x20.
REQ-035 Flush to 16'hFFFE: PC_out FFFE, FFFF, 0000 with PC_plus1 FFFF, 0000, 0001.
REQ-036 rst=1 asserted during STALL with a full skid: all outputs return to reset values; after deassertion the fetch restarts at 0.
